data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//   Shares the single byte-addressed data RAM between two requesters:
//   port A (instruction fetch) and port B (load/store).
//   Arbitration is round-robin with a registered req/ack handshake.
//   Every RAM access is sequenced as address/data setup, an Enable strobe,
//   then data capture.
//   Misaligned or reserved-size accesses are rejected before they reach the RAM.
// PARAMETERS
//   ADDR_W         32  address width on the requester and RAM sides
//   DATA_W         32  data width
//   STROBE_CYCLES  1   cycles MemEnable is held high per access; must be >=1
// PORTS
//   clk                         in   1       rising-edge clock
//   rst_n                       in   1       asynchronous active-low reset
//   AReq / BReq                 in   1       access request, held until Ack
//   ARW / BRW                   in   1       0=read, 1=write
//   ASize / BSize               in   2       00=byte, 01=half-word, 10=word, 11=reserved
//   AAddr / BAddr               in   ADDR_W  byte address
//   AWData / BWData             in   DATA_W  write data, right-justified
//   AAck / BAck                 out  1       one-cycle completion pulse
//   AErr / BErr                 out  1       valid with Ack; 1=rejected, no RAM access
//   ARData / BRData             out  DATA_W  read data, valid from Ack onward
//   MemEnable                   out  1       RAM Enable strobe
//   MemReadWrite                out  1       RAM ReadWrite
//   MemSize                     out  2       RAM Size
//   MemAddress / MemDataIn      out  ADDR_W / DATA_W  RAM address, write data
//   MemDataOut                  in   DATA_W  RAM read data
//   Busy                        out  1       1 when the state is not IDLE
// BEHAVIOUR
//   Reset (async, immediate)
//   - State=IDLE; all outputs, including MemEnable, go to 0 at once.
//   - LastGrant=B, so A wins the first tie.
//   - An in-flight access is abandoned and produces no Ack.
//   States: IDLE -> SETUP -> STROBE -> CAPTURE -> RESP -> IDLE; IDLE -> RESP on error.
//   IDLE
//   - If any Req is high at the edge, the winner is chosen:
//     - only one Req high: that requester;
//     - both high: the requester that is not LastGrant.
//   - The winner's RW, Size, Addr and WData are latched.
//   - Error cases: Size=11; Size=01 and Addr[0]=1; Size=10 and Addr[1:0]!=0.
//     An error goes straight to RESP with Err=1.
//   SETUP
//   - Mem* buses are driven from the latched values; MemEnable=0.
//   - MemDataIn = latched WData on writes, 0 on reads.
//   STROBE
//   - MemEnable=1 for exactly STROBE_CYCLES cycles (internal counter); buses stable.
//   CAPTURE
//   - MemEnable=0; buses are still held.
//   - On a read, the winner's RData <= MemDataOut, taken unmodified.
//   - On a write, RData is unchanged.
//   RESP
//   - The winner's Ack=1 for one cycle; Err is valid with it.
//   - LastGrant <= winner; the loser sees no Ack.
//   - Mem buses return to 0.
//   Latency
//   - Req is sampled at edge 0; Ack is high in the cycle after edge 3+STROBE_CYCLES.
//   - With STROBE_CYCLES=1 that is the 4th edge.
//   - An error Ack is high in the cycle after edge 1.
//   Handshake
//   - Req and the request fields must be stable until Ack.
//   - Dropping Req mid-access is ignored: the access completes and Ack still pulses.
//   - Req still high at the edge after Ack is treated as a new request.
//   - Back-to-back accesses are allowed; there is 1 IDLE cycle between them.
//   Starvation: with both Req held high, grants strictly alternate A,B,A,B.
//   RData holds its value until the next read completes for that port.
// TESTING
//   1 Reset while in STROBE (rst_n=0) -> MemEnable=0 and Busy=0 at once;
//     no AAck/BAck; next A word read from 0 works.
//   2 A word read, addr 4, STROBE_CYCLES=1 -> MemEnable high exactly 1 cycle;
//     AAck in cycle after edge 4; ARData = MemDataOut from CAPTURE; AErr=0.
//   3 Same edge: A byte write 8'hB5 to addr 0, and B byte read from addr 0
//     -> A served first; then B; BRData=32'h000000B5.
//   4 AReq and BReq held high for 4 accesses -> Ack order A,B,A,B;
//     Busy low exactly 1 cycle between accesses.
//   5 B half-word read from addr 3 -> BAck=BErr=1 in cycle after edge 1;
//     MemEnable never rises; then A word write of 32'hE35D8AC5 to addr 8
//     completes normally.
//   6 STROBE_CYCLES=3, A half-word write 16'hFFD3 to addr 2 -> MemEnable high
//     3 consecutive cycles; MemSize=01; MemAddress=2; AAck after edge 6.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one byte-addressed data RAM between fetch (A) and load/store (B).
// Each access is sequenced setup -> enable strobe -> capture -> response; bad size/alignment
// is rejected without touching the RAM.
module data_mem_arbiter #(
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned STROBE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req_i,
   input  logic              a_rw_i,
   input  logic [1:0]        a_size_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [DATA_W-1:0] a_wdata_i,
   output logic              a_ack_o,
   output logic              a_err_o,
   output logic [DATA_W-1:0] a_rdata_o,
   input  logic              b_req_i,
   input  logic              b_rw_i,
   input  logic [1:0]        b_size_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [DATA_W-1:0] b_wdata_i,
   output logic              b_ack_o,
   output logic              b_err_o,
   output logic [DATA_W-1:0] b_rdata_o,
   output logic              mem_enable_o,
   output logic              mem_read_write_o,
   output logic [1:0]        mem_size_o,
   output logic [ADDR_W-1:0] mem_address_o,
   output logic [DATA_W-1:0] mem_data_in_o,
   input  logic [DATA_W-1:0] mem_data_out_i,
   output logic              busy_o
);

   localparam int unsigned CntW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

   typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StCapture, StResp} state_e;

   state_e            state_q;
   logic              grant_b_q;
   logic              last_b_q;
   logic              rw_q;
   logic              err_q;
   logic [CntW-1:0]   cnt_q;
   logic              a_ack_q, a_err_q, b_ack_q, b_err_q;
   logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
   logic              mem_en_q, mem_rw_q;
   logic [1:0]        mem_size_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   logic              win_b;
   logic              sel_rw;
   logic [1:0]        sel_size;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_err;

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      win_b = b_req_i;
      if (a_req_i && b_req_i) begin
         win_b = ~last_b_q;
      end
      sel_rw    = win_b ? b_rw_i    : a_rw_i;
      sel_size  = win_b ? b_size_i  : a_size_i;
      sel_addr  = win_b ? b_addr_i  : a_addr_i;
      sel_wdata = win_b ? b_wdata_i : a_wdata_i;
      sel_err   = (sel_size == 2'b11) ||
                  ((sel_size == 2'b01) && sel_addr[0]) ||
                  ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         grant_b_q   <= 1'b0;
         last_b_q    <= 1'b1;
         rw_q        <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         a_ack_q     <= 1'b0;
         a_err_q     <= 1'b0;
         b_ack_q     <= 1'b0;
         b_err_q     <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_rw_q    <= 1'b0;
         mem_size_q  <= 2'b00;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         a_ack_q <= 1'b0;
         a_err_q <= 1'b0;
         b_ack_q <= 1'b0;
         b_err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (a_req_i || b_req_i) begin
                  grant_b_q <= win_b;
                  rw_q      <= sel_rw;
                  err_q     <= sel_err;
                  if (sel_err) begin
                     state_q <= StResp;
                  end else begin
                     mem_rw_q    <= sel_rw;
                     mem_size_q  <= sel_size;
                     mem_addr_q  <= sel_addr;
                     mem_wdata_q <= sel_rw ? sel_wdata : '0;
                     state_q     <= StSetup;
                  end
               end
            end
            StSetup: begin
               mem_en_q <= 1'b1;
               cnt_q    <= '0;
               state_q  <= StStrobe;
            end
            StStrobe: begin
               if (cnt_q == CntW'(STROBE_CYCLES - 1)) begin
                  mem_en_q <= 1'b0;
                  state_q  <= StCapture;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StCapture: begin
               if (!rw_q) begin
                  if (grant_b_q) b_rdata_q <= mem_data_out_i;
                  else           a_rdata_q <= mem_data_out_i;
               end
               mem_rw_q    <= 1'b0;
               mem_size_q  <= 2'b00;
               mem_addr_q  <= '0;
               mem_wdata_q <= '0;
               state_q     <= StResp;
            end
            StResp: begin
               if (grant_b_q) begin
                  b_ack_q <= 1'b1;
                  b_err_q <= err_q;
               end else begin
                  a_ack_q <= 1'b1;
                  a_err_q <= err_q;
               end
               last_b_q <= grant_b_q;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign a_ack_o          = a_ack_q;
   assign a_err_o          = a_err_q;
   assign a_rdata_o        = a_rdata_q;
   assign b_ack_o          = b_ack_q;
   assign b_err_o          = b_err_q;
   assign b_rdata_o        = b_rdata_q;
   assign mem_enable_o     = mem_en_q;
   assign mem_read_write_o = mem_rw_q;
   assign mem_size_o       = mem_size_q;
   assign mem_address_o    = mem_addr_q;
   assign mem_data_in_o    = mem_wdata_q;
   assign busy_o           = (state_q != StIdle);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a small byte RAM model behind the default instance and a
// second instance with a 3-cycle strobe.
module tb_data_mem_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        a_req = 0, a_rw = 0, b_req = 0, b_rw = 0;
   logic [1:0]  a_size = 0, b_size = 0;
   logic [31:0] a_addr = 0, b_addr = 0, a_wdata = 0, b_wdata = 0;
   logic        a_ack, a_err, b_ack, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic        m_en, m_rw, busy;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_din, m_dout;

   logic        d2_req = 0, d2_rw = 0;
   logic [1:0]  d2_size = 0;
   logic [31:0] d2_addr = 0, d2_wdata = 0, d2_dout = 0;
   logic        d2_a_ack, d2_a_err, d2_b_ack, d2_b_err;
   logic [31:0] d2_a_rdata, d2_b_rdata;
   logic        d2_en, d2_rw_o, d2_busy;
   logic [1:0]  d2_size_o;
   logic [31:0] d2_addr_o, d2_din;

   data_mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .a_req_i(a_req), .a_rw_i(a_rw), .a_size_i(a_size), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
      .a_ack_o(a_ack), .a_err_o(a_err), .a_rdata_o(a_rdata),
      .b_req_i(b_req), .b_rw_i(b_rw), .b_size_i(b_size), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
      .b_ack_o(b_ack), .b_err_o(b_err), .b_rdata_o(b_rdata),
      .mem_enable_o(m_en), .mem_read_write_o(m_rw), .mem_size_o(m_size),
      .mem_address_o(m_addr), .mem_data_in_o(m_din), .mem_data_out_i(m_dout), .busy_o(busy)
   );

   data_mem_arbiter #(.STROBE_CYCLES(3)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .a_req_i(d2_req), .a_rw_i(d2_rw), .a_size_i(d2_size), .a_addr_i(d2_addr),
      .a_wdata_i(d2_wdata), .a_ack_o(d2_a_ack), .a_err_o(d2_a_err), .a_rdata_o(d2_a_rdata),
      .b_req_i(1'b0), .b_rw_i(1'b0), .b_size_i(2'b00), .b_addr_i(32'h0), .b_wdata_i(32'h0),
      .b_ack_o(d2_b_ack), .b_err_o(d2_b_err), .b_rdata_o(d2_b_rdata),
      .mem_enable_o(d2_en), .mem_read_write_o(d2_rw_o), .mem_size_o(d2_size_o),
      .mem_address_o(d2_addr_o), .mem_data_in_o(d2_din), .mem_data_out_i(d2_dout),
      .busy_o(d2_busy)
   );

   // Byte RAM: preloaded with ram[i] = i while reset is low, written on enabled write edges.
   logic [7:0] ram [64];
   logic [5:0] ridx;
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) ram[i] <= 8'(i);
      end else if (m_en && m_rw) begin
         ram[m_addr[5:0]] <= m_din[7:0];
         if (m_size != 2'b00) ram[m_addr[5:0] + 6'd1] <= m_din[15:8];
         if (m_size == 2'b10) begin
            ram[m_addr[5:0] + 6'd2] <= m_din[23:16];
            ram[m_addr[5:0] + 6'd3] <= m_din[31:24];
         end
      end
   end

   always_comb begin
      ridx   = m_addr[5:0];
      m_dout = {24'h0, ram[ridx]};
      if (m_size == 2'b01) m_dout = {16'h0, ram[ridx + 6'd1], ram[ridx]};
      if (m_size == 2'b10) m_dout = {ram[ridx + 6'd3], ram[ridx + 6'd2], ram[ridx + 6'd1], ram[ridx]};
   end

   int checks = 0, errors = 0;
   int en1_cnt = 0, idle_cnt = 0, d2_run = 0, d2_max = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (m_en) en1_cnt++;
      if (!busy) idle_cnt++;
      if (d2_en) begin
         d2_run++;
         if (d2_run > d2_max) d2_max = d2_run;
      end else begin
         d2_run = 0;
      end
   endtask

   // lat is the edge index (0 = request edge) after which an Ack was seen, -1 if none.
   task automatic wait_ack(input int max, output int lat, output logic got_b, output logic err);
      lat   = -1;
      got_b = 1'b0;
      err   = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (a_ack || b_ack) begin
            lat   = i;
            got_b = b_ack;
            err   = b_ack ? b_err : a_err;
            return;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   int   lat;
   logic gb, er;

   initial begin
      do_reset();
      check_eq("reset_busy", 32'(busy), 32'd0);
      check_eq("reset_en", 32'(m_en), 32'd0);
      check_eq("reset_ack", 32'({a_ack, b_ack}), 32'd0);
      check_eq("reset_rdata", a_rdata, 32'h0);

      // 1: reset while strobing
      a_req = 1; a_rw = 0; a_size = 2'b10; a_addr = 32'd0;
      tick(); tick();
      check_eq("t1_in_strobe", 32'(m_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t1_rst_en", 32'(m_en), 32'd0);
      check_eq("t1_rst_busy", 32'(busy), 32'd0);
      a_req = 0;
      tick(); tick();
      check_eq("t1_no_ack", 32'({a_ack, b_ack}), 32'd0);
      rst_n = 1'b1;
      a_req = 1;
      wait_ack(10, lat, gb, er);
      a_req = 0;
      check_eq("t1_lat", 32'(lat), 32'd4);
      check_eq("t1_rdata", a_rdata, 32'h03020100);

      // 2: A word read at 4
      en1_cnt = 0;
      a_req = 1; a_addr = 32'd4;
      wait_ack(10, lat, gb, er);
      a_req = 0;
      check_eq("t2_lat", 32'(lat), 32'd4);
      check_eq("t2_who", 32'(gb), 32'd0);
      check_eq("t2_err", 32'(er), 32'd0);
      check_eq("t2_en_cycles", 32'(en1_cnt), 32'd1);
      check_eq("t2_rdata", a_rdata, 32'h07060504);

      // 3: simultaneous A byte write and B byte read after reset
      do_reset();
      a_req = 1; a_rw = 1; a_size = 2'b00; a_addr = 32'd0; a_wdata = 32'h000000B5;
      b_req = 1; b_rw = 0; b_size = 2'b00; b_addr = 32'd0;
      wait_ack(10, lat, gb, er);
      a_req = 0;
      check_eq("t3_first_who", 32'(gb), 32'd0);
      check_eq("t3_first_lat", 32'(lat), 32'd4);
      wait_ack(10, lat, gb, er);
      b_req = 0;
      check_eq("t3_second_who", 32'(gb), 32'd1);
      check_eq("t3_second_lat", 32'(lat), 32'd4);
      check_eq("t3_brdata", b_rdata, 32'h000000B5);

      // 4: both held for four accesses
      a_req = 1; a_rw = 0; a_size = 2'b10; a_addr = 32'd0;
      b_req = 1; b_rw = 0; b_size = 2'b10; b_addr = 32'd4;
      idle_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         wait_ack(10, lat, gb, er);
         if (k == 3) begin
            a_req = 0;
            b_req = 0;
         end
         check_eq($sformatf("t4_who%0d", k), 32'(gb), 32'(k % 2));
         check_eq($sformatf("t4_lat%0d", k), 32'(lat), 32'd4);
      end
      check_eq("t4_idle_cycles", 32'(idle_cnt), 32'd4);
      check_eq("t4_ardata", a_rdata, 32'h030201B5);
      check_eq("t4_brdata", b_rdata, 32'h07060504);

      // 5: misaligned B half-word, then A word write
      en1_cnt = 0;
      b_req = 1; b_rw = 0; b_size = 2'b01; b_addr = 32'd3;
      wait_ack(10, lat, gb, er);
      b_req = 0;
      check_eq("t5_err_lat", 32'(lat), 32'd1);
      check_eq("t5_err_who", 32'(gb), 32'd1);
      check_eq("t5_err", 32'(er), 32'd1);
      check_eq("t5_no_en", 32'(en1_cnt), 32'd0);
      a_req = 1; a_rw = 1; a_size = 2'b10; a_addr = 32'd8; a_wdata = 32'hE35D8AC5;
      wait_ack(10, lat, gb, er);
      a_req = 0;
      check_eq("t5_wr_lat", 32'(lat), 32'd4);
      check_eq("t5_wr_err", 32'(er), 32'd0);
      check_eq("t5_ram", {ram[11], ram[10], ram[9], ram[8]}, 32'hE35D8AC5);
      check_eq("t5_rdata_kept", a_rdata, 32'h030201B5);

      // reserved size and misaligned word on A
      a_req = 1; a_rw = 0; a_size = 2'b11; a_addr = 32'd0;
      wait_ack(10, lat, gb, er);
      a_req = 0;
      check_eq("rsv_err", 32'({lat[3:0], er}), {27'h0, 4'd1, 1'b1});
      a_req = 1; a_size = 2'b10; a_addr = 32'd2;
      wait_ack(10, lat, gb, er);
      a_req = 0;
      check_eq("misal_word_err", 32'({lat[3:0], er}), {27'h0, 4'd1, 1'b1});

      // 6: three-cycle strobe instance, half-word write
      d2_req = 1; d2_rw = 1; d2_size = 2'b01; d2_addr = 32'd2; d2_wdata = 32'h0000FFD3;
      d2_run = 0; d2_max = 0;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (d2_en) begin
            check_eq("t6_size", 32'(d2_size_o), 32'd1);
            check_eq("t6_addr", d2_addr_o, 32'd2);
            check_eq("t6_din", d2_din, 32'h0000FFD3);
         end
         if (d2_a_ack || d2_b_ack) begin
            lat = i;
            d2_req = 0;
            break;
         end
      end
      check_eq("t6_lat", 32'(lat), 32'd6);
      check_eq("t6_en_run", 32'(d2_max), 32'd3);
      check_eq("t6_err", 32'({d2_a_err, d2_b_ack}), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
